// File: rtl/arcade_input_mapper.sv
// PS/2 + joystick input mapper for arcade cores: held-key decode, orientation remap, timed coin pulses.
// Optional autofire on joystick bit 8 is enabled by defining AUTOFIRE_EN.
module arcade_input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter int COIN_PULSE  = 2400000,
  parameter int COIN_W      = 22,
  parameter int START_COINS = 1
`ifdef AUTOFIRE_EN
  , parameter int AUTOFIRE_HALF = 1200000
`endif
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [64:0]            ps2_key,
  input  logic [15:0]            joystick_0,
  input  logic [15:0]            joystick_1,
  input  logic                   orient,
  output logic [NUM_PLAYERS-1:0] p_up,
  output logic [NUM_PLAYERS-1:0] p_down,
  output logic [NUM_PLAYERS-1:0] p_left,
  output logic [NUM_PLAYERS-1:0] p_right,
  output logic [NUM_PLAYERS-1:0] p_fire,
  output logic [NUM_PLAYERS-1:0] start,
  output logic [NUM_PLAYERS-1:0] coin
);

  localparam logic [COIN_W-1:0] COIN_LAST = COIN_W'(COIN_PULSE - 1);
  localparam logic [1:0]        PL_MASK   = (NUM_PLAYERS > 1) ? 2'b11 : 2'b01;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} coin_st_t;

  logic              tog_q, armed_q, key_evt, pressed, extended;
  logic [8:0]        code;
  logic [14:0]       key_q, key_d;
  logic [1:0]        raw_up, raw_dn, raw_lt, raw_rt, fire_base, fire_d, start_d, req, req_edge;
  logic [1:0]        up_q, dn_q, lt_q, rt_q, fire_q, start_q, coin_q, req_q, pend_q;
  coin_st_t          st_q  [2];
  logic [COIN_W-1:0] cnt_q [2];
  logic              unused_joy;

  // The first clock after reset only captures the toggle bit, so a stale toggle is not an event.
  assign key_evt  = armed_q & (ps2_key[64] ^ tog_q);
  assign pressed  = (ps2_key[15:8] != 8'hF0);
  assign extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
  assign code     = (ps2_key[63:24] != '0) ? 9'h000 : {extended, ps2_key[7:0]};

  // key bits: 0-3 P1 U/D/L/R, 4 space, 5 ctrl, 6 F1, 7 coin1, 8-11 P2 U/D/L/R, 12 fire2, 13 F2, 14 coin2
  always_comb begin
    key_d = key_q;
    if (key_evt) begin
      case (code[7:0])
        8'h75:   key_d[0] = pressed;
        8'h72:   key_d[1] = pressed;
        8'h6B:   key_d[2] = pressed;
        8'h74:   key_d[3] = pressed;
        default: ;
      endcase
      case (code)
        9'h029:  key_d[4]  = pressed;
        9'h014:  key_d[5]  = pressed;
        9'h005:  key_d[6]  = pressed;
        9'h02E:  key_d[7]  = pressed;
        9'h02D:  key_d[8]  = pressed;
        9'h02B:  key_d[9]  = pressed;
        9'h023:  key_d[10] = pressed;
        9'h034:  key_d[11] = pressed;
        9'h01C:  key_d[12] = pressed;
        9'h006:  key_d[13] = pressed;
        9'h036:  key_d[14] = pressed;
        default: ;
      endcase
    end
  end

  assign raw_up    = {key_d[8]  | joystick_1[3], key_d[0] | joystick_0[3]};
  assign raw_dn    = {key_d[9]  | joystick_1[2], key_d[1] | joystick_0[2]};
  assign raw_lt    = {key_d[10] | joystick_1[1], key_d[2] | joystick_0[1]};
  assign raw_rt    = {key_d[11] | joystick_1[0], key_d[3] | joystick_0[0]};
  assign fire_base = {key_d[12] | joystick_1[4], key_d[4] | key_d[5] | joystick_0[4]};
  assign start_d   = {key_d[13] | joystick_0[6] | joystick_1[6],
                      key_d[6]  | joystick_0[5] | joystick_1[5]};
  assign req       = PL_MASK & {key_d[14] | joystick_1[7] | ((START_COINS != 0) && start_d[1]),
                                key_d[7]  | joystick_0[7] | ((START_COINS != 0) && start_d[0])};
  assign req_edge  = req & ~req_q;

`ifdef AUTOFIRE_EN
  localparam int AF_W = $clog2(AUTOFIRE_HALF + 1);
  logic [AF_W-1:0] af_cnt_q [2];
  logic [1:0]      af_phase_q, af_hold;

  assign af_hold = {joystick_1[8], joystick_0[8]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      af_phase_q <= 2'b11;
      for (int p = 0; p < 2; p++) af_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!af_hold[p]) begin
          af_cnt_q[p]   <= '0;
          af_phase_q[p] <= 1'b1;
        end else if (af_cnt_q[p] == AF_W'(AUTOFIRE_HALF - 1)) begin
          af_cnt_q[p]   <= '0;
          af_phase_q[p] <= ~af_phase_q[p];
        end else begin
          af_cnt_q[p] <= af_cnt_q[p] + AF_W'(1);
        end
      end
    end
  end

  assign fire_d     = fire_base | (af_hold & af_phase_q);
  assign unused_joy = ^{joystick_0[15:9], joystick_1[15:9]};
`else
  assign fire_d     = fire_base;
  assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      key_q   <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      lt_q    <= '0;
      rt_q    <= '0;
      fire_q  <= '0;
      start_q <= '0;
      coin_q  <= '0;
      req_q   <= '0;
      pend_q  <= '0;
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= IDLE;
        cnt_q[p] <= '0;
      end
    end else begin
      tog_q   <= ps2_key[64];
      armed_q <= 1'b1;
      key_q   <= key_d;
      up_q    <= PL_MASK & (orient ? raw_lt : raw_up);
      dn_q    <= PL_MASK & (orient ? raw_rt : raw_dn);
      lt_q    <= PL_MASK & (orient ? raw_dn : raw_lt);
      rt_q    <= PL_MASK & (orient ? raw_up : raw_rt);
      fire_q  <= PL_MASK & fire_d;
      start_q <= PL_MASK & start_d;
      req_q   <= req;
      for (int p = 0; p < 2; p++) begin
        case (st_q[p])
          IDLE: if (req_edge[p]) begin
            st_q[p]   <= ACTIVE;
            coin_q[p] <= 1'b1;
            cnt_q[p]  <= '0;
          end
          ACTIVE: begin
            if (req_edge[p]) pend_q[p] <= 1'b1;
            if (cnt_q[p] == COIN_LAST) begin
              st_q[p]   <= GAP;
              coin_q[p] <= 1'b0;
              cnt_q[p]  <= '0;
            end else begin
              cnt_q[p] <= cnt_q[p] + COIN_W'(1);
            end
          end
          GAP: begin
            if (cnt_q[p] == COIN_LAST) begin
              cnt_q[p] <= '0;
              // an edge landing on the gap's last cycle is taken right away
              if (pend_q[p] || req_edge[p]) begin
                st_q[p]   <= ACTIVE;
                coin_q[p] <= 1'b1;
                pend_q[p] <= 1'b0;
              end else begin
                st_q[p] <= IDLE;
              end
            end else begin
              cnt_q[p] <= cnt_q[p] + COIN_W'(1);
              if (req_edge[p]) pend_q[p] <= 1'b1;
            end
          end
          default: st_q[p] <= IDLE;
        endcase
      end
    end
  end

  assign p_up    = up_q[NUM_PLAYERS-1:0];
  assign p_down  = dn_q[NUM_PLAYERS-1:0];
  assign p_left  = lt_q[NUM_PLAYERS-1:0];
  assign p_right = rt_q[NUM_PLAYERS-1:0];
  assign p_fire  = fire_q[NUM_PLAYERS-1:0];
  assign start   = start_q[NUM_PLAYERS-1:0];
  assign coin    = coin_q[NUM_PLAYERS-1:0];

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the per-core keyboard/joystick glue in each emu top.
- Decodes hps_io PS/2 key events into per-player held-button state and ORs in the MiSTer joysticks.
- Applies vertical/horizontal orientation remapping and drives timed coin pulses through a per-player coin state machine.
- Sits between hps_io and the arcade core; its outputs are active-high and the core inverts them.

Parameters:
- NUM_PLAYERS, 2, number of players, 1 or 2; player-2 outputs are tied 0 when 1.
- COIN_PULSE, 2400000, coin active length in CLK cycles (100 ms at 24 MHz); the gap length is equal.
- COIN_W, 22, coin counter width; must hold COIN_PULSE-1.
- START_COINS, 1, 1 means a start press also requests a coin (free-play style); 0 disables this.

Ports:
- CLK  in  1  system clock (clk_sys domain)
- RESET  in  1  asynchronous active-high reset
- ps2_key  in  65  hps_io key word; bit 64 toggles per event
- joystick_0  in  16  P1 joystick: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin
- joystick_1  in  16  P2 joystick, same layout
- orient  in  1  0 = vertical (native), 1 = horizontal (rotated)
- p_up  out  NUM_PLAYERS  per-player up
- p_down  out  NUM_PLAYERS  per-player down
- p_left  out  NUM_PLAYERS  per-player left
- p_right  out  NUM_PLAYERS  per-player right
- p_fire  out  NUM_PLAYERS  per-player fire
- start  out  NUM_PLAYERS  start1/start2
- coin  out  NUM_PLAYERS  timed coin pulse

Behaviour:
- Reset: all key-state registers, all outputs, and both coin FSMs go to IDLE with counters 0. The toggle tracker takes the current ps2_key[64] on the first clock after reset, so no spurious event fires.
- Event detection: an event occurs when ps2_key[64] differs from its value on the previous cycle.
  - pressed = (ps2_key[15:8] != F0).
  - extended = pressed ? ps2_key[15:8]==E0 : ps2_key[23:16]==E0.
  - code = {extended, ps2_key[7:0]}.
  - code is forced to 0 when ps2_key[63:24] is nonzero (PRNSCR/PAUSE filter).
- Key map (the event writes `pressed` into the held bit; the extended bit is ignored for arrows):
  - P1: 75 up, 72 down, 6B left, 74 right; 029 or 014 fire; 005 (F1) start1; 02E ('5') coin1.
  - P2: 02D up, 02B down, 023 left, 034 right; 01C fire; 006 (F2) start2; 036 ('6') coin2.
- Merge: for each player, raw direction = key | joystick bit; fire = key | joy[4].
  - start1 = F1 | joystick_0[5] | joystick_1[5].
  - start2 = F2 | joystick_0[6] | joystick_1[6].
- Rotation, when orient=1:
  - up takes raw left; down takes raw right.
  - left takes raw down; right takes raw up.
  - orient=0 is a passthrough.
- Output latency: all outputs are registered. Each updates 1 cycle after a key event or joystick change.
- Coin request for player n = coin key | joystick_n[7] | (START_COINS & start_n). The FSM acts on the rising edge of the request.
- Coin FSM per player, states IDLE, ACTIVE, GAP:
  - IDLE: on a request edge, go to ACTIVE, set coin=1, cnt=0.
  - ACTIVE: cnt increments each cycle. When cnt==COIN_PULSE-1, go to GAP with coin=0 and cnt=0.
  - GAP: when cnt==COIN_PULSE-1, go to IDLE, or straight to ACTIVE if pending=1 (pending is then cleared).
  - A request edge seen in ACTIVE or GAP sets pending. Only one is held; further edges are dropped.
  - A request edge in the same cycle as the GAP-end transition counts as pending, so it is taken immediately.
- Held levels: a request held high continuously produces only one pulse.
- Reset during ACTIVE: coin drops to 0 asynchronously and pending clears.

Optional Feature:
- Macro: AUTOFIRE_EN.
- Defined:
  - Parameter AUTOFIRE_HALF (default 1200000) sets the half-period.
  - While joystick_n[8] is held, p_fire[n] is a square wave with period 2*AUTOFIRE_HALF that starts high.
  - The phase counter resets when joystick_n[8] is released.
  - Manual fire ORs over the square wave.
- Undefined: joystick bit 8 is ignored and fire is the plain merge.

Test Plan:
- Press then release on the same code: ps2_key={40'h0,8'h00,8'h75} with bit64 toggled, then {..,8'hF0,8'h75} toggled -> p_up[0]=1 one cycle after the first toggle, 0 one cycle after the second.
- Extended arrow: {..,8'hE0,8'h75} toggled (extended up) -> p_up[0]=1 one cycle after the toggle. Then PRNSCR with ps2_key[63:24]!=0 toggled -> no output change.
- Rotation: orient=1, joystick_0[1]=1 (left) -> p_up[0]=1 and p_left[0]=0. With orient=0 -> p_left[0]=1.
- Coin timing, with COIN_PULSE=8: pulse joystick_1[7] for 1 cycle -> coin[1] high for exactly 8 cycles, then low for at least 8 cycles.
- Coin pending, with COIN_PULSE=8: request edges at t=0, t=3 (ACTIVE) and t=10 (GAP) -> exactly two pulses, the second starting at t=16. Request held constantly high -> a single pulse.
- Reset mid-pulse: assert RESET at ACTIVE cnt=4 -> coin=0 in the same cycle and the FSM is in IDLE. A pending request is lost and no pulse follows deassertion.
